// File: rtl/operand_entry_if.sv
// Operand entry bus: switches, raw buttons and adder sum in; operands, result and state out.
// The controller uses the slave modport; the board/adder side uses master.
interface operand_entry_if;
   logic [3:0] sw;
   logic       btn_enter;
   logic       btn_clear;
   logic [3:0] sum_in;
   logic [3:0] num1;
   logic [3:0] num2;
   logic       cin;
   logic [3:0] result;
   logic       result_valid;
   logic [1:0] state;

   modport slave (
      input  sw, btn_enter, btn_clear, sum_in,
      output num1, num2, cin, result, result_valid, state
   );

   modport master (
      output sw, btn_enter, btn_clear, sum_in,
      input  num1, num2, cin, result, result_valid, state
   );
endinterface

// File: rtl/operand_entry_ctrl.sv
// Two-operand entry controller: debounced enter/clear buttons step an FSM that loads
// num1/num2 from the switches and captures the external adder's 4-bit sum.
module operand_entry_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input logic            clk,
   input logic            rst,
   operand_entry_if.slave bus
);

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_WAIT = 2'd2,
      S_RES  = 2'd3
   } state_t;

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Index 0 is enter, index 1 is clear.
   logic [1:0]    sync1, sync2, deb, deb_q;
   logic [CW-1:0] cnt [2];
   logic [1:0]    press;

   state_t     state_q;
   logic [3:0] num1_q, num2_q, result_q;
   logic       valid_q;

   // NOTE: every sequential block uses non-blocking assignments so all registers
   // sample their inputs from the same edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         sync1 <= {bus.btn_clear, bus.btn_enter};
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= ~deb[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // One-cycle pulse in the cycle after the debounced level rises.
   assign press = deb & ~deb_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_A;
         num1_q   <= '0;
         num2_q   <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else if (press[1]) begin
         // Clear takes priority; a coincident enter pulse is dropped.
         state_q  <= S_A;
         num1_q   <= '0;
         num2_q   <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_A: if (press[0]) begin
               num1_q  <= bus.sw;
               state_q <= S_B;
            end
            S_B: if (press[0]) begin
               num2_q  <= bus.sw;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               result_q <= bus.sum_in;
               valid_q  <= 1'b1;
               state_q  <= S_RES;
            end
            S_RES: if (press[0]) begin
               valid_q <= 1'b0;
               state_q <= S_A;
            end
         endcase
      end
   end

   assign bus.num1         = num1_q;
   assign bus.num2         = num2_q;
   assign bus.cin          = 1'b0;
   assign bus.result       = result_q;
   assign bus.result_valid = valid_q;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl with a 4-cycle debounce and an ideal 4-bit adder.
module tb_operand_entry_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   operand_entry_if bus ();

   operand_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.sum_in = bus.num1 + bus.num2;

   typedef struct packed {
      logic [3:0] sw;
      logic       enter;
      logic       clear;
      logic [1:0] exp_state;
      logic [3:0] exp_num1;
      logic [3:0] exp_num2;
      logic [3:0] exp_result;
      logic       exp_valid;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [1:0] st, input logic [3:0] n1,
                                input logic [3:0] n2, input logic [3:0] res, input logic v);
      check({tag, " state"}, 8'(bus.state), 8'(st));
      check({tag, " num1"}, 8'(bus.num1), 8'(n1));
      check({tag, " num2"}, 8'(bus.num2), 8'(n2));
      check({tag, " result"}, 8'(bus.result), 8'(res));
      check({tag, " valid"}, 8'(bus.result_valid), 8'(v));
      check({tag, " cin"}, 8'(bus.cin), 8'h0);
   endtask

   // Hold the buttons long enough to debounce the press, then release and settle.
   task automatic press(input logic [3:0] s, input logic e, input logic c);
      @(posedge clk); #1;
      bus.sw        = s;
      bus.btn_enter = e;
      bus.btn_clear = c;
      repeat (10) @(posedge clk);
      #1;
      bus.btn_enter = 1'b0;
      bus.btn_clear = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   initial begin
      bit found;

      vecs[0]  = '{4'hF, 1'b1, 1'b0, 2'd1, 4'hF, 4'h0, 4'h0, 1'b0};
      vecs[1]  = '{4'hF, 1'b1, 1'b0, 2'd3, 4'hF, 4'hF, 4'hE, 1'b1};
      vecs[2]  = '{4'h3, 1'b1, 1'b0, 2'd0, 4'hF, 4'hF, 4'hE, 1'b0};
      vecs[3]  = '{4'h9, 1'b1, 1'b0, 2'd1, 4'h9, 4'hF, 4'hE, 1'b0};
      vecs[4]  = '{4'h6, 1'b1, 1'b0, 2'd3, 4'h9, 4'h6, 4'hF, 1'b1};
      vecs[5]  = '{4'h0, 1'b1, 1'b0, 2'd0, 4'h9, 4'h6, 4'hF, 1'b0};
      vecs[6]  = '{4'h1, 1'b1, 1'b0, 2'd1, 4'h1, 4'h6, 4'hF, 1'b0};
      vecs[7]  = '{4'h1, 1'b0, 1'b1, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[8]  = '{4'h5, 1'b1, 1'b1, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[9]  = '{4'h7, 1'b1, 1'b0, 2'd1, 4'h7, 4'h0, 4'h0, 1'b0};
      vecs[10] = '{4'hA, 1'b1, 1'b0, 2'd3, 4'h7, 4'hA, 4'h1, 1'b1};
      vecs[11] = '{4'h4, 1'b0, 1'b1, 2'd0, 4'h0, 4'h0, 4'h0, 1'b0};

      rst           = 1'b1;
      bus.sw        = 4'h0;
      bus.btn_enter = 1'b0;
      bus.btn_clear = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs("reset", 2'd0, 4'h0, 4'h0, 4'h0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (vecs[i]) begin
         press(vecs[i].sw, vecs[i].enter, vecs[i].clear);
         @(negedge clk);
         check_outputs($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_num1,
                       vecs[i].exp_num2, vecs[i].exp_result, vecs[i].exp_valid);
      end

      // S_B -> S_WAIT -> S_RES timing: result appears exactly one cycle after num2.
      press(4'h2, 1'b1, 1'b0);
      @(posedge clk); #1;
      bus.sw        = 4'h3;
      bus.btn_enter = 1'b1;
      found         = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (bus.state == 2'd2) found = 1'b1;
      end
      check("latency reach S_WAIT", 8'(found), 8'h1);
      check("latency num2", 8'(bus.num2), 8'h3);
      check("latency valid low", 8'(bus.result_valid), 8'h0);
      @(negedge clk);
      check("latency state S_RES", 8'(bus.state), 8'h3);
      check("latency valid high", 8'(bus.result_valid), 8'h1);
      check("latency result", 8'(bus.result), 8'h5);
      @(posedge clk); #1;
      bus.btn_enter = 1'b0;
      repeat (10) @(posedge clk);
      press(4'h0, 1'b1, 1'b0);
      @(negedge clk);
      check("back to S_A", 8'(bus.state), 8'h0);

      // Short glitches must not survive the debouncer.
      @(posedge clk); #1;
      bus.sw = 4'h1;
      for (int g = 0; g < 3; g++) begin
         bus.btn_enter = 1'b1;
         repeat (2) @(posedge clk);
         #1 bus.btn_enter = 1'b0;
         @(posedge clk); #1;
      end
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("glitch state", 8'(bus.state), 8'h0);
      check("glitch num1", 8'(bus.num1), 8'h2);
      press(4'h1, 1'b1, 1'b0);
      @(negedge clk);
      check("hold single pulse state", 8'(bus.state), 8'h1);
      check("hold num1", 8'(bus.num1), 8'h1);
      press(4'h1, 1'b1, 1'b0);
      @(negedge clk);
      check("pre-reset state", 8'(bus.state), 8'h3);
      check("pre-reset result", 8'(bus.result), 8'h2);

      // Asynchronous reset between edges, with enter held through its release.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_outputs("async reset", 2'd0, 4'h0, 4'h0, 4'h0, 1'b0);
      bus.sw        = 4'hC;
      bus.btn_enter = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("held through reset state", 8'(bus.state), 8'h1);
      check("held through reset num1", 8'(bus.num1), 8'hC);
      @(posedge clk); #1;
      bus.btn_enter = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("release no pulse", 8'(bus.state), 8'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_entry_ctrl.md
OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, number of consecutive stable clk cycles required to accept a button level change; legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sw  input  4  operand switches, sampled only on an accepted enter press.
REQ-005 btn_enter  input  1  raw, unsynchronized, bouncing enter button, active-high.
REQ-006 btn_clear  input  1  raw, unsynchronized, bouncing clear button, active-high.
REQ-007 sum_in  input  4  sum returned by the downstream 4-bit adder, combinational function of num1/num2.
REQ-008 num1  output  4  registered operand A driven to the adder.
REQ-009 num2  output  4  registered operand B driven to the adder.
REQ-010 cin  output  1  adder carry-in, constant 0.
REQ-011 result  output  4  registered captured sum.
REQ-012 result_valid  output  1  high while result holds a sum for the current num1/num2.
REQ-013 state  output  2  current FSM state encoding, for LEDs.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Debounce: per button, a counter SHALL reset whenever the synchronized level equals the debounced level, else increment; when it reaches DEBOUNCE_CYCLES-1, the debounced level SHALL toggle and the counter SHALL clear.
REQ-016 Press pulse: a single-cycle pulse SHALL be asserted in the cycle after the debounced level goes 0->1; a held button SHALL yield exactly one pulse; release SHALL yield none.
REQ-017 FSM states/encoding: S_A=2'd0, S_B=2'd1, S_WAIT=2'd2, S_RES=2'd3; state output SHALL equal the current state register.
REQ-018 S_A + enter pulse: num1<=sw, next S_B.
REQ-019 S_B + enter pulse: num2<=sw, next S_WAIT.
REQ-020 S_WAIT: unconditionally result<=sum_in, result_valid<=1, next S_RES (exactly one cycle; enter pulses in S_WAIT SHALL be ignored).
REQ-021 S_RES + enter pulse: result_valid<=0, next S_A; num1, num2 and result SHALL hold until overwritten.
REQ-022 Clear pulse in any state: num1, num2, result<=0, result_valid<=0, next S_A.
REQ-023 Simultaneous enter and clear pulses: clear SHALL win; the enter pulse SHALL be discarded.
REQ-024 Latency: enter pulse in S_B at cycle n -> num2 updated at n+1, result_valid high from n+2.
REQ-025 Arithmetic: result is the adder's 4-bit sum modulo 16; the block SHALL NOT compute or flag carry-out.
REQ-026 No output SHALL change except as stated in REQ-018..REQ-022.

Reset
REQ-027 While rst=1: state=S_A, num1=num2=result=0, result_valid=0, cin=0, synchronizers, debounced levels and counters all 0; effect immediate, independent of clk.
REQ-028 Reset asserted mid-operation (any state, mid-debounce) SHALL abort it; a button held through reset release SHALL produce one press pulse after DEBOUNCE_CYCLES stable cycles.

Verification (DEBOUNCE_CYCLES=4, adder model sum_in=num1+num2 mod 16)
REQ-029 Press/release enter with sw=4'b1111, then again with sw=4'b1111 -> num1=num2=4'b1111, result=4'b1110, result_valid=1 two cycles after second pulse, state=3.
REQ-030 Enter sequence sw=4'b1001 then 4'b0110 -> result=4'b1111; third enter -> result_valid=0, state=0, result still 4'b1111.
REQ-031 btn_enter glitches high for 2 cycles, repeated 3 times with 1-cycle gaps, in S_A -> no pulse, state stays 0; a 10-cycle hold -> exactly one pulse, state 1.
REQ-032 Enter A=4'b0001, then clear in S_B -> num1=0, num2=0, result=0, state=0; simultaneous enter+clear pulses in S_A -> state stays 0, num1 unchanged 0.
REQ-033 Assert rst asynchronously between clk edges while in S_RES with result=4'b0010 -> all outputs 0 and state=0 immediately, before the next clk edge.
